// File: rtl/sha256_host_feeder.sv
`default_nettype none
// ============================================================================
// Module   : sha256_host_feeder
// Purpose  : Host-side driver for a single-block SHA-256 core. Buffers a
//            1..MAX_BYTES message from a byte stream, streams the padded
//            64-byte block into the core, collects the 16 x 16-bit digest
//            words and presents the 256-bit result on a valid/ready output.
//            Over-long messages are drained and reported with m_error.
// Ports    : clk, rst_n                  clock, async active-low reset
//            s_valid/s_ready/s_data/s_last   message byte stream in
//            core_load/core_msg/core_hash    SHA-256 core byte interface
//            m_valid/m_ready/m_digest/m_error result out
//            busy                        high unless idle in COLLECT
// Revision : 1.0  initial release
// ============================================================================
module sha256_host_feeder #(
  parameter int MAX_BYTES  = 55,
  parameter int HASH_LAT   = 99,
  parameter int HASH_WORDS = 16,
  parameter int GAP        = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  input  logic         s_last,
  output logic         core_load,
  output logic [7:0]   core_msg,
  input  logic [15:0]  core_hash,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [255:0] m_digest,
  output logic         m_error,
  output logic         busy
);

  localparam int LW = 6;
  localparam int CW = $clog2(HASH_LAT + HASH_WORDS + GAP + 2);

  localparam logic [LW-1:0] C_MAX_LEN   = LW'(MAX_BYTES);
  localparam logic [CW-1:0] C_LAST_BYTE = CW'(63);
  localparam logic [CW-1:0] C_WAIT_END  = CW'(HASH_LAT);
  localparam logic [CW-1:0] C_CAP_END   = CW'(HASH_LAT + HASH_WORDS);
  localparam logic [CW-1:0] C_GAP_END   = CW'(HASH_LAT + HASH_WORDS + GAP);

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_DROP    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_GAP     = 3'd5,
    ST_RESULT  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            core_load_q, core_load_d;
  logic [7:0]      core_msg_q, core_msg_d;
  logic            m_valid_q, m_valid_d;
  logic            m_error_q, m_error_d;
  logic [255:0]    digest_q, digest_d;
  logic            busy_q, busy_d;
  logic [7:0]      buf_q [MAX_BYTES];
  logic            buf_wr, buf_clr;

  logic [LW-1:0]   w_idx;
  logic [15:0]     w_len_bits;
  logic [7:0]      w_pad;

  assign s_ready   = rst_n && (state_q == ST_COLLECT || state_q == ST_DROP);
  assign core_load = core_load_q;
  assign core_msg  = core_msg_q;
  assign m_valid   = m_valid_q;
  assign m_error   = m_error_q;
  assign m_digest  = digest_q;
  assign busy      = busy_q;

  // The register stage means the byte chosen while cnt_q == i is the one the
  // core sees in the following cycle; cnt_q therefore runs one ahead of the
  // core-visible cycle number (core_load is visible while cnt_q == 1).
  assign w_idx      = cnt_q[LW-1:0];
  assign w_len_bits = {7'd0, len_q, 3'd0};

  always_comb begin
    w_pad = 8'h00;
    if (w_idx < len_q)       w_pad = buf_q[w_idx];
    else if (w_idx == len_q) w_pad = 8'h80;
    else if (w_idx == 6'd62) w_pad = w_len_bits[15:8];
    else if (w_idx == 6'd63) w_pad = w_len_bits[7:0];
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    core_load_d = 1'b0;
    core_msg_d  = 8'h00;
    m_valid_d   = m_valid_q;
    m_error_d   = m_error_q;
    digest_d    = digest_q;
    buf_wr      = 1'b0;
    buf_clr     = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        if (s_valid) begin
          if (len_q == C_MAX_LEN) begin
            // This byte would not fit in one block.
            if (s_last) begin
              state_d   = ST_RESULT;
              m_valid_d = 1'b1;
              m_error_d = 1'b1;
              digest_d  = '0;
            end else begin
              state_d = ST_DROP;
            end
          end else begin
            buf_wr = 1'b1;
            len_d  = len_q + 6'd1;
            if (s_last) begin
              state_d = ST_SEND;
              cnt_d   = '0;
            end
          end
        end
      end
      ST_DROP: begin
        if (s_valid && s_last) begin
          state_d   = ST_RESULT;
          m_valid_d = 1'b1;
          m_error_d = 1'b1;
          digest_d  = '0;
        end
      end
      ST_SEND: begin
        core_load_d = (cnt_q == '0);
        core_msg_d  = w_pad;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == C_LAST_BYTE) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_WAIT_END) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // Word k is sampled while cnt_q == HASH_LAT+1+k, i.e. core cycle HASH_LAT+k.
        digest_d = {digest_q[239:0], core_hash};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == C_CAP_END) state_d = ST_GAP;
      end
      ST_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_GAP_END) begin
          state_d   = ST_RESULT;
          m_valid_d = 1'b1;
        end
      end
      ST_RESULT: begin
        if (m_ready) begin
          state_d   = ST_COLLECT;
          m_valid_d = 1'b0;
          m_error_d = 1'b0;
          digest_d  = '0;
          len_d     = '0;
          buf_clr   = 1'b1;
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    busy_d = !((state_d == ST_COLLECT) && (len_d == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      len_q       <= '0;
      cnt_q       <= '0;
      core_load_q <= 1'b0;
      core_msg_q  <= 8'h00;
      m_valid_q   <= 1'b0;
      m_error_q   <= 1'b0;
      digest_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      core_load_q <= core_load_d;
      core_msg_q  <= core_msg_d;
      m_valid_q   <= m_valid_d;
      m_error_q   <= m_error_d;
      digest_q    <= digest_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_BYTES; i++) buf_q[i] <= 8'h00;
    end else if (buf_clr) begin
      for (int i = 0; i < MAX_BYTES; i++) buf_q[i] <= 8'h00;
    end else if (buf_wr) begin
      buf_q[len_q] <= s_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_host_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_host_feeder
// Purpose  : Self-checking bench for sha256_host_feeder. Contains a model of
//            the SHA-256 core (captures the 64 streamed bytes, returns the
//            digest words at the fixed latency, garbage otherwise) and a
//            message-level reference (padding + SHA-256 compression).
// Revision : 1.0  initial release
// ============================================================================
module tb_sha256_host_feeder;

  localparam int HASH_LAT = 99;
  localparam int NWORDS   = 16;
  localparam int GAPC     = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid, s_ready, s_last;
  logic [7:0]   s_data;
  logic         core_load;
  logic [7:0]   core_msg;
  logic [15:0]  core_hash;
  logic         m_valid, m_ready, m_error, busy;
  logic [255:0] m_digest;

  int tests = 0;
  int fails = 0;

  sha256_host_feeder #(.MAX_BYTES(55), .HASH_LAT(HASH_LAT), .HASH_WORDS(NWORDS), .GAP(GAPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .core_load(core_load), .core_msg(core_msg), .core_hash(core_hash),
    .m_valid(m_valid), .m_ready(m_ready), .m_digest(m_digest), .m_error(m_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- SHA-256 reference ----------------
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    logic [31:0] iv [8];
    iv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = iv[0]; b = iv[1]; c = iv[2]; d = iv[3]; e = iv[4]; f = iv[5]; g = iv[6]; h = iv[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {iv[0]+a, iv[1]+b, iv[2]+c, iv[3]+d, iv[4]+e, iv[5]+f, iv[6]+g, iv[7]+h};
  endfunction

  // Padded block: message, 0x80, zeros, 64-bit big-endian bit length.
  function automatic logic [511:0] ref_block(input logic [7:0] m [$]);
    logic [511:0] r;
    int L;
    L = m.size();
    r = '0;
    for (int i = 0; i < L; i++) r[511-8*i -: 8] = m[i];
    r[511-8*L -: 8] = 8'h80;
    r[63:0] = 64'(L * 8);
    return r;
  endfunction

  // ---------------- core model ----------------
  logic [7:0]   cblk [64];
  int           ph = 0;
  int           loads = 0;
  int           load_glitch = 0;
  int           cyc = 0;
  int           load_cyc_q [$];
  logic [255:0] core_dig = '0;

  function automatic logic [511:0] core_block();
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[511-8*i -: 8] = cblk[i];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph        <= 0;
      core_hash <= 16'h0000;
    end else begin
      if (core_load) begin
        if (ph > 0 && ph < 64) load_glitch <= load_glitch + 1;
        cblk[0] <= core_msg;
        ph      <= 1;
        loads   <= loads + 1;
        load_cyc_q.push_back(cyc);
      end else if (ph > 0 && ph < 64) begin
        cblk[ph] <= core_msg;
        ph       <= ph + 1;
      end else if (ph >= 64 && ph < 300) begin
        ph <= ph + 1;
      end
      if (ph == 64) core_dig <= sha256(core_block());
      // Digest word k is driven during core cycle HASH_LAT+k only.
      if (!core_load && ph + 1 >= HASH_LAT && ph + 1 < HASH_LAT + NWORDS)
        core_hash <= core_dig[255 - 16*(ph + 1 - HASH_LAT) -: 16];
      else
        core_hash <= 16'($urandom);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_msg(input logic [7:0] m [$], input int gap_pct);
    int t;
    for (int i = 0; i < m.size(); i++) begin
      while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = m[i];
      s_last  = (i == m.size() - 1);
      t = 0;
      while (!s_ready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) begin
        tests++; fails++;
        $display("FAIL s_ready_timeout byte %0d: s_ready=%b, required 1", i, s_ready);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic get_result(input int hold, input bit early, output logic [255:0] dig,
                            output logic err, output logic [511:0] blk);
    int t;
    bit stable;
    if (early) m_ready = 1'b1;
    t = 0;
    while (!m_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (t >= 3000) begin
      fails++;
      $display("FAIL m_valid_timeout: m_valid=%b, required 1", m_valid);
    end
    dig = m_digest;
    err = m_error;
    blk = core_block();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_in_result: busy=%b, required 1", busy);
    end
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_digest !== dig || m_error !== err) stable = 1'b0;
    end
    if (hold > 0) begin
      tests++;
      if (!stable) begin
        fails++;
        $display("FAIL result_stable: m_valid=%b m_error=%b digest=%h, required held %h", m_valid, m_error, m_digest, dig);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL accept: m_valid=%b busy=%b, required 0 0", m_valid, busy);
    end
  endtask

  // Runs one message end to end and checks it against the reference.
  task automatic run_check(input string name, input logic [7:0] m [$], input int gap_pct,
                           input int hold, output logic [255:0] dig);
    logic err;
    logic [511:0] blk, exp_blk;
    int l0;
    l0 = loads;
    drive_msg(m, gap_pct);
    get_result(hold, 1'b0, dig, err, blk);
    if (m.size() <= 55) begin
      exp_blk = ref_block(m);
      tests++;
      if (blk !== exp_blk || loads != l0 + 1) begin
        fails++;
        $display("FAIL %s block: got %h loads+%0d, required %h loads+1", name, blk, loads - l0, exp_blk);
      end
      tests++;
      if (dig !== sha256(exp_blk) || err !== 1'b0) begin
        fails++;
        $display("FAIL %s digest: got %h err=%b, required %h err=0", name, dig, err, sha256(exp_blk));
      end
    end else begin
      tests++;
      if (dig !== '0 || err !== 1'b1 || loads != l0) begin
        fails++;
        $display("FAIL %s overflow: got digest %h err=%b loads+%0d, required 0 1 +0", name, dig, err, loads - l0);
      end
    end
  endtask

  function automatic void fill(ref logic [7:0] m [$], input int n, input int val);
    m.delete();
    for (int i = 0; i < n; i++) m.push_back((val < 0) ? 8'($urandom) : 8'(val));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (s_ready !== 1'b0 || core_load !== 1'b0 || core_msg !== 8'h00 || m_valid !== 1'b0 ||
        m_digest !== '0 || m_error !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: s_ready=%b load=%b msg=%h m_valid=%b err=%b busy=%b, required all 0",
               s_ready, core_load, core_msg, m_valid, m_error, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: s_ready=%b, required 1", s_ready);
    end
  endtask

  task automatic test_abc();
    logic [7:0] m [$];
    logic [255:0] d;
    logic [511:0] b;
    m = '{8'h61, 8'h62, 8'h63};
    run_check("abc", m, 0, 0, d);
    b = core_block();
    tests++;
    if (b[511-8*3 -: 8] !== 8'h80 || b[7:0] !== 8'h18 || b[15:8] !== 8'h00) begin
      fails++;
      $display("FAIL abc_pad: byte3=%h byte62=%h byte63=%h, required 80 00 18", b[511-24 -: 8], b[15:8], b[7:0]);
    end
    tests++;
    if (d !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) begin
      fails++;
      $display("FAIL abc_golden: got %h", d);
    end
  endtask

  task automatic test_max_len();
    logic [7:0] m [$];
    logic [255:0] d;
    logic [511:0] b;
    fill(m, 55, 8'h61);
    run_check("len55", m, 0, 0, d);
    b = core_block();
    tests++;
    if (b[511-8*55 -: 8] !== 8'h80 || b[15:8] !== 8'h01 || b[7:0] !== 8'hB8) begin
      fails++;
      $display("FAIL len55_pad: byte55=%h byte62=%h byte63=%h, required 80 01 b8", b[511-440 -: 8], b[15:8], b[7:0]);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] m [$];
    logic [255:0] d;
    fill(m, 60, -1);
    run_check("ovf60", m, 20, 0, d);
    fill(m, 56, -1);
    run_check("ovf56", m, 0, 0, d);
  endtask

  task automatic test_gaps_hold();
    logic [7:0] m [$];
    logic [255:0] d;
    int lens [4] = '{1, 17, $urandom_range(2, 54), 55};
    for (int k = 0; k < 4; k++) begin
      fill(m, lens[k], -1);
      run_check($sformatf("gap%0d", k), m, 50, 20, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1 [$], m2 [$];
    logic [255:0] d1, d2;
    logic e1, e2;
    logic [511:0] b1, b2;
    int l0, dl;
    m1 = '{8'h61, 8'h62, 8'h63};
    m2 = '{8'h61};
    l0 = loads;
    fork
      begin drive_msg(m1, 0); drive_msg(m2, 0); end
      begin get_result(0, 1'b0, d1, e1, b1); get_result(0, 1'b1, d2, e2, b2); end
    join
    tests++;
    if (d1 !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad || e1 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: got %h err=%b", d1, e1);
    end
    tests++;
    if (d2 !== 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb || e2 !== 1'b0 ||
        b2 !== ref_block(m2)) begin
      fails++;
      $display("FAIL b2b_second: got %h err=%b", d2, e2);
    end
    dl = (load_cyc_q.size() >= 2) ? load_cyc_q[$] - load_cyc_q[$-1] : 0;
    tests++;
    if (loads != l0 + 2 || dl < HASH_LAT + NWORDS + GAPC) begin
      fails++;
      $display("FAIL b2b_spacing: loads+%0d spacing=%0d, required +2 and >=%0d", loads - l0, dl, HASH_LAT + NWORDS + GAPC);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] m [$];
    logic [255:0] d;
    int l0, t;
    m = '{8'h61, 8'h62, 8'h63};
    l0 = loads;
    drive_msg(m, 0);
    t = 0;
    while (loads == l0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (80) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || loads != l0 + 1) begin
      fails++;
      $display("FAIL mid_wait_state: busy=%b loads+%0d, required 1 +1", busy, loads - l0);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (s_ready !== 1'b0 || core_load !== 1'b0 || core_msg !== 8'h00 || m_valid !== 1'b0 ||
        m_digest !== '0 || m_error !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs: s_ready=%b load=%b msg=%h m_valid=%b err=%b busy=%b, required all 0",
               s_ready, core_load, core_msg, m_valid, m_error, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_release_ready: s_ready=%b, required 1", s_ready);
    end
    @(negedge clk);
    run_check("after_reset", m, 0, 0, d);
    tests++;
    if (d !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad || load_glitch != 0) begin
      fails++;
      $display("FAIL after_reset_golden: got %h glitches=%0d", d, load_glitch);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_max_len();
    test_overflow();
    test_gaps_hold();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
